// File: rtl/imem_loader.sv
//==============================================================================
// Module      : imem_loader
// Description : Receives a valid/ready byte stream and writes the assembled
//               32-bit little-endian words to the instruction memory write
//               port at byte addresses stepping by 4. Asserts busy for the
//               whole load session so the fetch front end can stall.
//               Optional feature macro: CHECKSUM_EN (trailing 32-bit sum of
//               the written words, mismatch reported on err).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef CHECKSUM_EN
    localparam logic [2:0] S_CKSUM = 3'd4;
    // Sessions always finish through the checksum phase, even empty ones.
    localparam logic [2:0] S_LAST  = S_CKSUM;
`else
    localparam logic [2:0] S_LAST  = S_DONE;
`endif

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  num_lat;
    logic [CNT_W-1:0]  word_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       byte_buf;   // bytes 0..2 of the word being assembled

    logic              xfer;
    logic [31:0]       full_word;
    logic [CNT_W-1:0]  next_cnt;

    // Handshake and the word completed by the byte on the bus this cycle
    assign xfer      = in_valid & in_ready;
    assign full_word = {in_data, byte_buf};
    assign next_cnt  = word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef CHECKSUM_EN
    assign in_ready = (state == S_RECV) || (state == S_CKSUM);
`else
    assign in_ready = (state == S_RECV);
`endif
    assign wr_en = (state == S_WRITE);
    assign done  = (state == S_DONE);
    assign busy  = (state != S_IDLE);

`ifdef CHECKSUM_EN
    logic [31:0] sum;
    logic        err_r;

    assign err = err_r;

    // Running sum of written words and comparison against the trailing word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= 32'd0;
            err_r <= 1'b0;
        end else begin
            if (state == S_IDLE && start && !abort) begin
                sum   <= 32'd0;
                err_r <= 1'b0;
            end else if (state == S_WRITE) begin
                sum <= sum + wr_data;
            end else if (state == S_CKSUM && !abort && xfer && byte_idx == 2'd3) begin
                err_r <= (full_word != sum);
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    // Session sequencing, byte assembly and write-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cur_addr <= '0;
            num_lat  <= '0;
            word_cnt <= '0;
            byte_idx <= 2'd0;
            byte_buf <= 24'd0;
            wr_addr  <= '0;
            wr_data  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        cur_addr <= base_addr & ~ADDR_W'(3);
                        num_lat  <= num_words;
                        word_cnt <= '0;
                        byte_idx <= 2'd0;
                        state    <= (num_words == '0) ? S_LAST : S_RECV;
                    end
                end
`ifdef CHECKSUM_EN
                S_RECV, S_CKSUM: begin
`else
                S_RECV: begin
`endif
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (xfer) begin
                        case (byte_idx)
                            2'd0:    byte_buf[7:0]   <= in_data;
                            2'd1:    byte_buf[15:8]  <= in_data;
                            2'd2:    byte_buf[23:16] <= in_data;
                            default: byte_buf        <= byte_buf;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (state == S_RECV) begin
                                wr_addr <= cur_addr;
                                wr_data <= full_word;
                                state   <= S_WRITE;
                            end else begin
                                state   <= S_DONE;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    cur_addr <= cur_addr + ADDR_W'(4);
                    word_cnt <= next_cnt;
                    byte_idx <= 2'd0;
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (next_cnt == num_lat) begin
                        state <= S_LAST;
                    end else begin
                        state <= S_RECV;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//==============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Expected writes are
//               queued as stimulus is driven; a monitor queues observed
//               writes, and each scenario task compares the two queues.
//               Build with CHECKSUM_EN defined to exercise the checksum.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [8:0]  num_words = 9'd0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          done_cyc = 0;

    imem_loader #(.ADDR_W(32), .CNT_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: record writes and done pulses between clock edges
    always @(negedge clk) begin
        if (wr_en) begin
            obs_q.push_back({wr_addr, wr_data});
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the byte transferred
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int guard;
        bit ok;
        guard = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
            guard++;
            if (guard > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL byte_handshake_timeout: in_ready stayed %0b, required 1", in_ready);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send_byte(t[7:0], rnd);
        end
    endtask

    task automatic send_cksum(input logic [31:0] s);
`ifdef CHECKSUM_EN
        send_word(s, 1'b0);
`else
        s = s;
`endif
    endtask

    task automatic do_start(input logic [31:0] b, input logic [8:0] n);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b want 0", done); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b want 0", err); end
        vectors++; if (wr_addr !== 32'd0 || wr_data !== 32'd0) begin miscompares++; $display("FAIL reset_wr_bus: got %h/%h want 0/0", wr_addr, wr_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int d0;
        d0 = done_cnt;
        do_start(32'h0, 9'd2);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_after_start: got %0b want 1", busy); end
        exp_q.push_back({32'h0000_0000, 32'h0031_81B3});
        exp_q.push_back({32'h0000_0004, 32'h0211_C063});
        send_byte(8'hB3, 1'b0); send_byte(8'h81, 1'b0); send_byte(8'h31, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h63, 1'b0); send_byte(8'hC0, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h02, 1'b0);
        send_cksum(32'h0031_81B3 + 32'h0211_C063);
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL basic_write: got none want %h", e); end
            else begin logic [63:0] o; o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL basic_write: got %h want %h", o, e); end end
        end
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL basic_extra_writes: got %0d want 0", obs_q.size()); obs_q.delete(); end
        vectors++; if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want %0d", done_cnt - d0, 1); end
`ifndef CHECKSUM_EN
        vectors++; if (done_cyc != last_wr_cyc + 1) begin miscompares++; $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_wr_cyc + 1); end
`endif
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %0b want 0", busy); end
    endtask

    task automatic test_align;
        do_start(32'h13, 9'd1);
        exp_q.push_back({32'h0000_0010, 32'h0011_0113});
        send_word(32'h0011_0113, 1'b0);
        send_cksum(32'h0011_0113);
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL align_write: got none want %h", e); end
            else begin logic [63:0] o; o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL align_write: got %h want %h", o, e); end end
        end
    endtask

    task automatic test_random_valid;
        logic [31:0] w;
        logic [31:0] s;
        s = 32'd0;
        do_start(32'h200, 9'd3);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            s = s + w;
            exp_q.push_back({32'h200 + 32'(4 * i), w});
            send_word(w, 1'b1);
        end
        send_cksum(s);
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL random_write: got none want %h", e); end
            else begin logic [63:0] o; o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL random_write: got %h want %h", o, e); end end
        end
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL random_extra_writes: got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_abort;
        int d0;
        d0 = done_cnt;
        do_start(32'h300, 9'd4);
        exp_q.push_back({32'h300, 32'hA5A5_1234});
        send_word(32'hA5A5_1234, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL abort_write: got none want %h", e); end
            else begin logic [63:0] o; o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL abort_write: got %h want %h", o, e); end end
        end
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL abort_extra_writes: got %0d want 0", obs_q.size()); obs_q.delete(); end
        vectors++; if (done_cnt != d0) begin miscompares++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %0b want 0", busy); end
        // start together with abort in IDLE must not open a session
        @(negedge clk); start = 1'b1; abort = 1'b1; base_addr = 32'h500; num_words = 9'd1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_abort_busy: got %0b want 0", busy); end
        // a fresh start after an abort works normally
        do_start(32'h40, 9'd1);
        exp_q.push_back({32'h40, 32'hCAFE_F00D});
        send_word(32'hCAFE_F00D, 1'b0);
        send_cksum(32'hCAFE_F00D);
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL abort_restart_write: got none want %h", e); end
            else begin logic [63:0] o; o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL abort_restart_write: got %h want %h", o, e); end end
        end
        vectors++; if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL abort_restart_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid;
        int d0;
        do_start(32'h80, 9'd2);
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midreset_ctrl: got rdy=%0b busy=%0b wr=%0b done=%0b want 0000", in_ready, busy, wr_en, done); end
        vectors++; if (wr_addr !== 32'd0 || wr_data !== 32'd0) begin miscompares++; $display("FAIL midreset_wr_bus: got %h/%h want 0/0", wr_addr, wr_data); end
        @(negedge clk); rst_n = 1'b1;
        // empty session: done, no writes
        d0 = done_cnt;
        do_start(32'h90, 9'd0);
        send_cksum(32'd0);
        repeat (4) @(negedge clk);
        vectors++; if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL empty_done: got %0d want 1", done_cnt - d0); end
        vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL empty_writes: got %0d want 0", obs_q.size()); obs_q.delete(); end
        // start while busy is ignored
        d0 = done_cnt;
        do_start(32'h100, 9'd1);
        exp_q.push_back({32'h100, 32'h1234_5678});
        send_byte(8'h78, 1'b0);
        do_start(32'h200, 9'd5);
        send_byte(8'h56, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'h12, 1'b0);
        send_cksum(32'h1234_5678);
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL busy_start_write: got none want %h", e); end
            else begin logic [63:0] o; o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL busy_start_write: got %h want %h", o, e); end end
        end
        vectors++; if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL busy_start_done: got %0d want 1", done_cnt - d0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_idle: got %0b want 0", busy); end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum;
        do_start(32'h0, 9'd2);
        exp_q.push_back({32'h0, 32'h1});
        exp_q.push_back({32'h4, 32'h2});
        send_word(32'h1, 1'b0); send_word(32'h2, 1'b0);
        send_word(32'h3, 1'b0);
        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL cksum_write: got none want %h", e); end
            else begin logic [63:0] o; o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL cksum_write: got %h want %h", o, e); end end
        end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL cksum_good_err: got %0b want 0", err); end
        do_start(32'h0, 9'd2);
        send_word(32'h1, 1'b0); send_word(32'h2, 1'b0);
        send_word(32'h4, 1'b0);
        repeat (5) @(negedge clk);
        obs_q.delete();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL cksum_bad_err: got %0b want 1", err); end
        do_start(32'h0, 9'd0);
        @(negedge clk);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL cksum_err_clear: got %0b want 0", err); end
        @(posedge clk); #1;
        send_cksum(32'd0);
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_align;
        test_random_valid;
        test_abort;
        test_reset_mid;
`ifdef CHECKSUM_EN
        test_checksum;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound in case a scenario stalls
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
